border_scanner: RTL and testbench

BORDER_SCANNER -- requirements
Module: border_scanner

---
 rtl/border_scanner_if.sv | 51 +++++
 rtl/border_scanner.sv | 124 ++++++++++++
 tb/tb_border_scanner.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/border_scanner_if.sv
// Border scanner bus: frame request, coordinate probe to the border
// generator, and the row stream handed to the display.
//
// Row stream handshake: the scanner raises row_valid with row_data and
// row_idx stable; a row is transferred on a rising clock edge where both
// row_valid and row_ready are high. While row_valid is high and row_ready
// is low, row_data, row_idx, x and y do not change. row_valid never rises
// outside a pending row, and row_ready is ignored while no row is offered.
interface border_scanner_if;
  logic        start;
  logic [3:0]  x;
  logic [3:0]  y;
  logic        is_border;
  logic [15:0] row_data;
  logic [3:0]  row_idx;
  logic        row_valid;
  logic        row_ready;
  logic        busy;
  logic        done;
  logic [8:0]  border_count;

  // Scanner side: drives coordinates and the row stream.
  modport master (
    input  start,
    input  is_border,
    input  row_ready,
    output x,
    output y,
    output row_data,
    output row_idx,
    output row_valid,
    output busy,
    output done,
    output border_count
  );

  // Environment side: requests frames, answers probes, consumes rows.
  modport slave (
    output start,
    output is_border,
    output row_ready,
    input  x,
    input  y,
    input  row_data,
    input  row_idx,
    input  row_valid,
    input  busy,
    input  done,
    input  border_count
  );
endinterface

// File: rtl/border_scanner.sv
// Border scanner: walks a COLS x ROWS grid one pixel per cycle, asks a
// combinational generator whether (x,y) is a border pixel, packs each row
// into a bitmap and hands it downstream over a valid/ready stream.
// A frame ends with a one-cycle done pulse; border_count keeps the total
// for the finished frame until the next start.
module border_scanner #(
  parameter int COLS = 16,
  parameter int ROWS = 16
) (
  input  logic              clk,
  input  logic              rst,
  border_scanner_if.master  bus,
  output logic [1:0]        state_dbg
);

  // Last legal coordinates, sized to the coordinate ports.
  localparam logic [3:0] X_LAST = 4'(COLS - 1);
  localparam logic [3:0] Y_LAST = 4'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  x_q;
  logic [3:0]  y_q;
  logic [15:0] row_data_q;
  logic [3:0]  row_idx_q;
  logic        row_valid_q;
  logic        busy_q;
  logic        done_q;
  logic [8:0]  border_count_q;

  // Frame sequencer: every output is a register updated here, so the
  // generator and the display see glitch-free coordinates and row data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      x_q            <= '0;
      y_q            <= '0;
      row_data_q     <= '0;
      row_idx_q      <= '0;
      row_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      border_count_q <= '0;
    end else begin
      // done is a single-cycle pulse; only the last row handshake sets it.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // Coordinates already rest at 0 here; a request opens a fresh frame.
          if (bus.start) begin
            state          <= SCAN;
            busy_q         <= 1'b1;
            x_q            <= '0;
            y_q            <= '0;
            row_data_q     <= '0;
            border_count_q <= '0;
          end
        end

        SCAN: begin
          // One pixel per cycle: record the generator answer for (x,y).
          // x never exceeds COLS-1, so bits at or above COLS stay cleared.
          row_data_q[x_q] <= bus.is_border;
          // At most 256 pixels per frame, so 9 bits never wrap.
          border_count_q  <= border_count_q + 9'(bus.is_border);
          if (x_q == X_LAST) begin
            // Row complete: x holds, offer the row downstream.
            state       <= SEND;
            row_valid_q <= 1'b1;
            row_idx_q   <= y_q;
          end else begin
            x_q <= x_q + 4'd1;
          end
        end

        SEND: begin
          // Nothing moves until the display takes the row.
          if (bus.row_ready) begin
            row_valid_q <= 1'b0;
            if (y_q == Y_LAST) begin
              // Last row taken: y and row_data keep their final values.
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state      <= SCAN;
              y_q        <= y_q + 4'd1;
              x_q        <= '0;
              row_data_q <= '0;
            end
          end
        end

        DONE: begin
          // start is deliberately not looked at here; only IDLE accepts it.
          state  <= IDLE;
          busy_q <= 1'b0;
          x_q    <= '0;
          y_q    <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.x            = x_q;
  assign bus.y            = y_q;
  assign bus.row_data     = row_data_q;
  assign bus.row_idx      = row_idx_q;
  assign bus.row_valid    = row_valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.border_count = border_count_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_border_scanner.sv
// Directed bench for border_scanner: a default 16x16 instance driven by a
// perimeter / constant generator, and an 8x4 instance with the generator
// tied high. Expected rows, counts and cycle numbers are hand-derived.
module tb_border_scanner;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Rising-edge counter: after edge n the bus shows cycle n+1 values.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  border_scanner_if bus_a ();
  border_scanner_if bus_s ();
  logic [1:0] dbg_a;
  logic [1:0] dbg_s;

  // Generator for the default instance: 0 = perimeter, 1 = all ones, 2 = all zeros.
  logic [1:0] gen_mode;
  assign bus_a.is_border = (gen_mode == 2'd0) ?
                           ((bus_a.x == 4'd0) || (bus_a.x == 4'd15) ||
                            (bus_a.y == 4'd0) || (bus_a.y == 4'd15)) :
                           (gen_mode == 2'd1);
  assign bus_s.is_border = 1'b1;

  border_scanner u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_a.master),
    .state_dbg (dbg_a)
  );

  border_scanner #(.COLS(8), .ROWS(4)) u_small (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_s.master),
    .state_dbg (dbg_s)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected rows of a 16x16 frame: perimeter pattern or all zeros.
  task automatic fill_exp(input bit zeros);
    exp_q.delete();
    for (int r = 0; r < 16; r++) begin
      if (zeros) exp_q.push_back(16'h0000);
      else if (r == 0 || r == 15) exp_q.push_back(16'hFFFF);
      else exp_q.push_back(16'h8001);
    end
  endtask

  // ---------------- driver / monitor for the 16x16 instance ----------------
  task automatic run_frame(input string name, input int stall_row, input int stall_len,
                           input bit poke, input int done_off, input int exp_count);
    int k;
    int rows_seen;
    int done_pulses;
    int done_cyc;
    int post;
    int stall_cnt;
    int budget;
    bit stall_done;
    bit busy_drop;
    logic [15:0] exp_row;
    rows_seen = 0; done_pulses = 0; done_cyc = -1; post = 0;
    stall_cnt = 0; budget = 0; stall_done = 1'b0; busy_drop = 1'b0;

    bus_a.row_ready = 1'b1;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    k = cyc;
    check({name, " busy_at_k1"}, 32'(bus_a.busy), 32'd1);

    while (post < 4 && budget < 600) begin
      budget++;
      if (done_cyc < 0 && bus_a.busy !== 1'b1) busy_drop = 1'b1;

      // Downstream back-pressure on the chosen row.
      bus_a.row_ready = 1'b1;
      if (bus_a.row_valid && stall_len > 0 && !stall_done && bus_a.row_idx == 4'(stall_row)) begin
        if (stall_cnt < stall_len) begin
          bus_a.row_ready = 1'b0;
          check({name, " stall_valid"}, 32'(bus_a.row_valid), 32'd1);
          check({name, " stall_data"}, 32'(bus_a.row_data), 32'h8001);
          check({name, " stall_idx"}, 32'(bus_a.row_idx), 32'(stall_row));
          check({name, " stall_x"}, 32'(bus_a.x), 32'd15);
          check({name, " stall_y"}, 32'(bus_a.y), 32'(stall_row));
          stall_cnt++;
        end else begin
          stall_done = 1'b1;
        end
      end

      if (bus_a.row_valid && bus_a.row_ready) begin
        if (rows_seen == 0) check({name, " row0_send_cycle"}, 32'(cyc + 1), 32'(k + 17));
        exp_row = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check({name, " row_data"}, 32'(bus_a.row_data), 32'(exp_row));
        check({name, " row_idx"}, 32'(bus_a.row_idx), 32'(rows_seen));
        rows_seen++;
      end

      // Stray start requests: during row 7 scan and during the done cycle.
      if (poke)
        bus_a.start = (bus_a.done || (bus_a.busy && !bus_a.row_valid &&
                       bus_a.y == 4'd7 && bus_a.x == 4'd4)) ? 1'b1 : 1'b0;

      if (bus_a.done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc + 1;
      end
      if (done_cyc >= 0 && !bus_a.done) post++;
      step();
    end
    bus_a.start = 1'b0;

    check({name, " done_cycle"}, 32'(done_cyc), 32'(k + done_off));
    check({name, " done_pulses"}, 32'(done_pulses), 32'd1);
    check({name, " rows"}, 32'(rows_seen), 32'd16);
    check({name, " border_count"}, 32'(bus_a.border_count), 32'(exp_count));
    check({name, " busy_held"}, 32'(busy_drop), 32'd0);
    check({name, " idle_after"}, 32'(bus_a.busy), 32'd0);
    check({name, " valid_after"}, 32'(bus_a.row_valid), 32'd0);
    check({name, " exp_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- driver / monitor for the 8x4 instance ----------------
  task automatic run_small();
    int k;
    int rows;
    int done_cyc;
    int budget;
    rows = 0; done_cyc = -1; budget = 0;
    bus_s.start = 1'b1;
    step();
    bus_s.start = 1'b0;
    k = cyc;
    while (done_cyc < 0 && budget < 100) begin
      budget++;
      if (bus_s.row_valid) begin
        check("small row_data", 32'(bus_s.row_data), 32'h00FF);
        check("small row_idx", 32'(bus_s.row_idx), 32'(rows));
        rows++;
      end
      if (bus_s.done) done_cyc = cyc + 1;
      else step();
    end
    check("small done_cycle", 32'(done_cyc), 32'(k + 37));
    check("small rows", 32'(rows), 32'd4);
    check("small border_count", 32'(bus_s.border_count), 32'd32);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int budget;
    bit bad;
    rst = 1'b0;
    gen_mode = 2'd0;
    bus_a.start = 1'b0;
    bus_a.row_ready = 1'b0;
    bus_s.start = 1'b0;
    bus_s.row_ready = 1'b1;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("reset x", 32'(bus_a.x), 32'd0);
    check("reset y", 32'(bus_a.y), 32'd0);
    check("reset row_valid", 32'(bus_a.row_valid), 32'd0);
    check("reset busy", 32'(bus_a.busy), 32'd0);
    check("reset done", 32'(bus_a.done), 32'd0);
    check("reset border_count", 32'(bus_a.border_count), 32'd0);
    check("reset state", 32'(dbg_a), 32'd0);
    #11 rst = 1'b0;
    step();
    step();

    // Perimeter frame, ready always high
    fill_exp(1'b0);
    run_frame("perimeter", -1, 0, 1'b0, 273, 60);

    // Back-pressure on row 3 for 5 cycles
    fill_exp(1'b0);
    run_frame("stall", 3, 5, 1'b0, 278, 60);

    // Stray start pulses mid-scan and in the done cycle
    fill_exp(1'b0);
    run_frame("restart_ignored", -1, 0, 1'b1, 273, 60);

    // Empty generator
    gen_mode = 2'd2;
    fill_exp(1'b1);
    run_frame("zeros", -1, 0, 1'b0, 273, 0);
    gen_mode = 2'd0;

    // 8x4 instance, generator tied high
    run_small();

    // Asynchronous reset during row 9 scan
    bus_a.row_ready = 1'b1;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    budget = 0;
    while (!(bus_a.busy && !bus_a.row_valid && bus_a.y == 4'd9 && bus_a.x == 4'd5) && budget < 400) begin
      budget++;
      step();
    end
    check("rst reached row9", 32'(bus_a.y), 32'd9);
    #2 rst = 1'b1;
    #1;
    check("async x", 32'(bus_a.x), 32'd0);
    check("async y", 32'(bus_a.y), 32'd0);
    check("async row_data", 32'(bus_a.row_data), 32'd0);
    check("async row_idx", 32'(bus_a.row_idx), 32'd0);
    check("async row_valid", 32'(bus_a.row_valid), 32'd0);
    check("async busy", 32'(bus_a.busy), 32'd0);
    check("async done", 32'(bus_a.done), 32'd0);
    check("async border_count", 32'(bus_a.border_count), 32'd0);
    check("async state", 32'(dbg_a), 32'd0);
    check("async small state", 32'(dbg_s), 32'd0);
    #1 rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus_a.row_valid || bus_a.busy || bus_a.done) bad = 1'b1;
    end
    check("quiet after reset", 32'(bad), 32'd0);

    // Start on the very first edge after a reset release
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    fill_exp(1'b0);
    run_frame("after_reset", -1, 0, 1'b0, 273, 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog: the directed sequence needs only a few thousand cycles.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
